hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage DLX core.
- Produces the write-enable, flush and bubble controls consumed by the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards, acts on taken branches resolved in ID, and holds the front end while a multi-cycle multiply occupies EX.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/dlx_pipe_pkg.sv | 13 +
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/load_use_detect.sv | 24 ++
 rtl/hazard_ctrl.sv | 105 ++++++++++
 tb/tb_hazard_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/dlx_pipe_pkg.sv
// Shared DLX pipeline definitions: register-specifier width, the R0 specifier
// and the hazard-controller state encoding.
package dlx_pipe_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] R0 = '0;

   // One-bit state encoding kept as plain constants for legacy tools
   typedef logic [0:0] state_t;
   localparam state_t RUN = 1'b0;
   localparam state_t MUL = 1'b1;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX hazard fields and pipeline-register controls between the DLX datapath
// (master) and the hazard controller (slave).
interface hazard_ctrl_if;
   import dlx_pipe_pkg::*;

   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_use_rs1;
   logic                  id_use_rs2;
   logic                  id_is_mul;
   logic                  br_taken;
   logic                  ex_is_load;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  PC_write;
   logic                  IFID_write;
   logic                  IFflush;
   logic                  IDEX_write;
   logic                  IDEX_bubble;
   logic                  mul_busy;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_mul,
             br_taken, ex_is_load, ex_rd,
      input  PC_write, IFID_write, IFflush, IDEX_write, IDEX_bubble, mul_busy
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_mul,
             br_taken, ex_is_load, ex_rd,
      output PC_write, IFID_write, IFflush, IDEX_write, IDEX_bubble, mul_busy
   );

endinterface

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of the load now in EX;
// writes to R0 never create a dependency.
module load_use_detect
   import dlx_pipe_pkg::*;
(
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_id_rs1,
   input  logic [REG_ADDR_W-1:0] i_id_rs2,
   input  logic                  i_id_use_rs1,
   input  logic                  i_id_use_rs2,
   input  logic                  i_ex_is_load,
   input  logic [REG_ADDR_W-1:0] i_ex_rd,
   output logic                  o_lu
);

   logic w_rs1_hit;
   logic w_rs2_hit;

   assign w_rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
   assign w_rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
   assign o_lu      = i_id_valid && i_ex_is_load && (i_ex_rd != R0) &&
                      (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// DLX pipeline hazard controller: load-use stall, taken-branch flush, multi-cycle
// multiply freeze, plus a saturating stall-cycle counter.
module hazard_ctrl
   import dlx_pipe_pkg::*;
#(
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 3,
   parameter int PERF_W  = 16
)
(
   input  logic              clk,
   input  logic              rst_n,
   hazard_ctrl_if.slave      io_hz,
   output logic [PERF_W-1:0] o_stall_cnt
);

   state_t            r_state;
   logic [CNT_W-1:0]  r_mul_cnt;
   logic [PERF_W-1:0] r_stall_cnt;

   state_t            w_next_state;
   logic [CNT_W-1:0]  w_next_cnt;
   logic              w_lu;
   logic              w_br;
   logic              w_mul_issue;
   logic              w_pc_write;
   logic              w_ifid_write;
   logic              w_ifflush;
   logic              w_idex_write;
   logic              w_idex_bubble;
   logic              w_mul_busy;

   load_use_detect u_lu (
      .i_id_valid   (io_hz.id_valid),
      .i_id_rs1     (io_hz.id_rs1),
      .i_id_rs2     (io_hz.id_rs2),
      .i_id_use_rs1 (io_hz.id_use_rs1),
      .i_id_use_rs2 (io_hz.id_use_rs2),
      .i_ex_is_load (io_hz.ex_is_load),
      .i_ex_rd      (io_hz.ex_rd),
      .o_lu         (w_lu)
   );

   assign w_br        = io_hz.id_valid && io_hz.br_taken;
   assign w_mul_issue = io_hz.id_valid && io_hz.id_is_mul;

   // Mealy control; priority in RUN is load-use, then branch, then multiply issue
   always_comb begin
      w_pc_write    = 1'b1;
      w_ifid_write  = 1'b1;
      w_ifflush     = 1'b0;
      w_idex_write  = 1'b1;
      w_idex_bubble = 1'b0;
      w_mul_busy    = 1'b0;
      w_next_state  = r_state;
      w_next_cnt    = r_mul_cnt;
      if (!rst_n) begin
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
         w_idex_write = 1'b0;
      end else if (r_state == MUL) begin
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
         w_idex_write = 1'b0;
         w_mul_busy   = 1'b1;
         if (r_mul_cnt == '0) begin
            w_next_state = RUN;
         end else begin
            w_next_cnt = r_mul_cnt - CNT_W'(1);
         end
      end else if (w_lu) begin
         w_pc_write    = 1'b0;
         w_ifid_write  = 1'b0;
         w_idex_bubble = 1'b1;
      end else if (w_br) begin
         w_ifflush = 1'b1;
      end else if (w_mul_issue && (MUL_LAT > 1)) begin
         w_next_state = MUL;
         w_next_cnt   = CNT_W'(MUL_LAT - 2);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_mul_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state   <= w_next_state;
         r_mul_cnt <= w_next_cnt;
         if (!w_pc_write && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
         end
      end
   end

   assign io_hz.PC_write    = w_pc_write;
   assign io_hz.IFID_write  = w_ifid_write;
   assign io_hz.IFflush     = w_ifflush;
   assign io_hz.IDEX_write  = w_idex_write;
   assign io_hz.IDEX_bubble = w_idex_bubble;
   assign io_hz.mul_busy    = w_mul_busy;
   assign o_stall_cnt       = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: one instance with MUL_LAT=4/PERF_W=16
// and one with MUL_LAT=1/PERF_W=4 for the single-cycle multiply and saturation cases.
module tb_hazard_ctrl;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       mul;
      logic       br;
      logic       ld;
      logic [4:0] rd;
   } stim_t;

   typedef struct {
      bit          sel;
      logic [5:0]  outs;
      logic [15:0] cnt;
      string       tag;
   } exp_t;

   // Output vector order: {PC_write, IFID_write, IFflush, IDEX_write, IDEX_bubble, mul_busy}
   localparam logic [5:0] RUNO = 6'b110100;
   localparam logic [5:0] LUO  = 6'b000110;
   localparam logic [5:0] BRO  = 6'b111100;
   localparam logic [5:0] MULO = 6'b000001;
   localparam logic [5:0] ZERO = 6'b000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] stcA;
   logic [3:0]  stcB;

   exp_t        expQ[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned cntA = 0;
   int unsigned cntB = 0;

   hazard_ctrl_if ifA ();
   hazard_ctrl_if ifB ();

   hazard_ctrl #(.MUL_LAT(4), .CNT_W(3), .PERF_W(16)) dutA (
      .clk         (clk),
      .rst_n       (rst_n),
      .io_hz       (ifA),
      .o_stall_cnt (stcA)
   );

   hazard_ctrl #(.MUL_LAT(1), .CNT_W(3), .PERF_W(4)) dutB (
      .clk         (clk),
      .rst_n       (rst_n),
      .io_hz       (ifB),
      .o_stall_cnt (stcB)
   );

   always #5 clk = ~clk;

   function automatic stim_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic mul,
                                input logic br, input logic ld, input logic [4:0] rd);
      stim_t s;
      s.valid = v;  s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
      s.mul   = mul; s.br = br;  s.ld  = ld;  s.rd = rd;
      return s;
   endfunction

   task automatic setA(input stim_t s);
      ifA.id_valid   = s.valid;
      ifA.id_rs1     = s.rs1;
      ifA.id_rs2     = s.rs2;
      ifA.id_use_rs1 = s.u1;
      ifA.id_use_rs2 = s.u2;
      ifA.id_is_mul  = s.mul;
      ifA.br_taken   = s.br;
      ifA.ex_is_load = s.ld;
      ifA.ex_rd      = s.rd;
   endtask

   task automatic setB(input stim_t s);
      ifB.id_valid   = s.valid;
      ifB.id_rs1     = s.rs1;
      ifB.id_rs2     = s.rs2;
      ifB.id_use_rs1 = s.u1;
      ifB.id_use_rs2 = s.u2;
      ifB.id_is_mul  = s.mul;
      ifB.br_taken   = s.br;
      ifB.ex_is_load = s.ld;
      ifB.ex_rd      = s.rd;
   endtask

   task automatic checkOutput();
      exp_t        e;
      logic [5:0]  o;
      logic [15:0] c;
      checks++;
      assert (expQ.size() > 0) else begin
         failures++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         if (e.sel) begin
            o = {ifB.PC_write, ifB.IFID_write, ifB.IFflush, ifB.IDEX_write, ifB.IDEX_bubble, ifB.mul_busy};
            c = {12'd0, stcB};
         end else begin
            o = {ifA.PC_write, ifA.IFID_write, ifA.IFflush, ifA.IDEX_write, ifA.IDEX_bubble, ifA.mul_busy};
            c = stcA;
         end
         checks++;
         assert (o === e.outs) else begin
            failures++;
            $error("FAIL %s_ctrl observed=%b expected=%b", e.tag, o, e.outs);
         end
         checks++;
         assert (c === e.cnt) else begin
            failures++;
            $error("FAIL %s_stall_cnt observed=%0d expected=%0d", e.tag, c, e.cnt);
         end
      end
   endtask

   // One clock step: drive at the falling edge, record the expectation, sample 1ns later
   task automatic applyStimulus(input bit sel, input logic rstv, input stim_t s,
                                input logic [5:0] expOut, input string tag);
      exp_t  e;
      stim_t idle;
      idle = '0;
      @(negedge clk);
      rst_n = rstv;
      if (sel) begin
         setA(idle);
         setB(s);
      end else begin
         setA(s);
         setB(idle);
      end
      if (!rstv) begin
         cntA = 0;
         cntB = 0;
      end
      e.sel  = sel;
      e.outs = expOut;
      e.cnt  = sel ? 16'(cntB) : 16'(cntA);
      e.tag  = tag;
      expQ.push_back(e);
      if (rstv && !expOut[5]) begin
         if (sel) cntB = (cntB == 15) ? 15 : cntB + 1;
         else     cntA = (cntA == 65535) ? 65535 : cntA + 1;
      end
      #1;
      checkOutput();
   endtask

   initial begin
      stim_t idle;
      idle = '0;
      setA(idle);
      setB(idle);

      applyStimulus(0, 1'b0, idle, ZERO, "resetA");
      applyStimulus(1, 1'b0, idle, ZERO, "resetB");
      applyStimulus(0, 1'b1, mk(1, 5'd1, 5'd2, 1, 1, 0, 0, 0, 5'd0), RUNO, "release");

      applyStimulus(0, 1'b1, mk(1, 5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5), LUO,  "lu_rs1");
      applyStimulus(0, 1'b1, mk(1, 5'd1, 5'd2, 1, 1, 0, 0, 0, 5'd0), RUNO, "after_lu");
      applyStimulus(0, 1'b1, mk(1, 5'd0, 5'd0, 1, 0, 0, 0, 1, 5'd0), RUNO, "lu_r0");
      applyStimulus(0, 1'b1, mk(1, 5'd5, 5'd0, 0, 0, 0, 0, 1, 5'd5), RUNO, "lu_nouse");
      applyStimulus(0, 1'b1, mk(1, 5'd3, 5'd7, 1, 1, 0, 0, 1, 5'd7), LUO,  "lu_rs2");
      applyStimulus(0, 1'b1, mk(1, 5'd3, 5'd7, 1, 1, 0, 0, 1, 5'd9), RUNO, "lu_nomatch");

      applyStimulus(0, 1'b1, mk(1, 5'd1, 5'd2, 1, 1, 0, 1, 0, 5'd0), BRO,  "branch");
      applyStimulus(0, 1'b1, mk(1, 5'd4, 5'd0, 1, 0, 0, 1, 1, 5'd4), LUO,  "branch_lu");
      applyStimulus(0, 1'b1, mk(1, 5'd4, 5'd0, 1, 0, 0, 1, 0, 5'd0), BRO,  "branch_after");
      applyStimulus(0, 1'b1, mk(0, 5'd5, 5'd0, 1, 0, 1, 1, 1, 5'd5), RUNO, "invalid_id");

      applyStimulus(0, 1'b1, mk(1, 5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0), RUNO, "mul_issue");
      applyStimulus(0, 1'b1, mk(1, 5'd1, 5'd2, 1, 1, 0, 1, 0, 5'd0), MULO, "mul_c1_br");
      applyStimulus(0, 1'b1, mk(1, 5'd6, 5'd0, 1, 0, 1, 0, 1, 5'd6), MULO, "mul_c2_lu");
      applyStimulus(0, 1'b1, mk(1, 5'd1, 5'd2, 1, 1, 1, 1, 0, 5'd0), MULO, "mul_c3");
      applyStimulus(0, 1'b1, mk(1, 5'd1, 5'd2, 1, 1, 0, 0, 0, 5'd0), RUNO, "mul_done");

      applyStimulus(0, 1'b1, mk(1, 5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0), RUNO, "mul2_issue");
      applyStimulus(0, 1'b1, idle, MULO, "mul2_c1");
      applyStimulus(0, 1'b1, idle, MULO, "mul2_c2");
      applyStimulus(0, 1'b0, idle, ZERO, "reset_mid_mul");
      applyStimulus(0, 1'b1, idle, RUNO, "release_mid_mul");
      applyStimulus(0, 1'b1, idle, RUNO, "run_after_abort");

      applyStimulus(1, 1'b1, mk(1, 5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0), RUNO, "mul1_issue");
      applyStimulus(1, 1'b1, mk(1, 5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0), RUNO, "mul1_back2back");
      applyStimulus(1, 1'b1, idle, RUNO, "mul1_idle");
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1, 1'b1, mk(1, 5'd8, 5'd0, 1, 0, 0, 0, 1, 5'd8), LUO, "sat_lu");
      end
      applyStimulus(1, 1'b1, idle, RUNO, "sat_hold");
      applyStimulus(1, 1'b1, idle, RUNO, "sat_hold2");

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
